// File: rtl/wishbone_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_pkg
// Shared Wishbone definitions used by the slave memory, the master and the
// verification components: cycle-type and burst-type encodings, the slave
// state enum and a helper that gives the wrap mask for a burst type.
// No ports.
// -----------------------------------------------------------------------------
package wishbone_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_XFER  = 2'b10,
        ST_BURST = 2'b11
    } wb_state_e;

    localparam int WCNT_W = 4;

    // Word-index bits that wrap for a given burst type; linear returns 0
    // because a linear burst has no wrapping field.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        logic [3:0] m;
        case (bte)
            BTE_WRAP4:  m = 4'b0011;
            BTE_WRAP8:  m = 4'b0111;
            BTE_WRAP16: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wishbone_slave_ram.sv
// -----------------------------------------------------------------------------
// wishbone_slave_ram
// Single-port word memory, 2**AW words of DW bits, per-byte write enable and
// synchronous read. The read register loads the addressed word when rd_en_i
// is high and clears to zero otherwise, so its output can drive the bus
// read data directly. Storage is never reset; only the read register is.
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (read register only)
//   addr_i   word address
//   we_i     write strobe
//   be_i     byte lane enables for the write
//   wdata_i  write data
//   rd_en_i  load the read register with the addressed word
//   rdata_o  registered read data (zero when not loading)
// -----------------------------------------------------------------------------
module wishbone_slave_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   addr_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            rd_en_i,
    output logic [DW-1:0]   rdata_o
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] bit_mask;

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < NB; b++) begin
            bit_mask[b*8 +: 8] = {8{be_i[b]}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
        end
    end

    // Read-before-write: a beat that writes returns the previous word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wishbone_slave_mem.sv
// -----------------------------------------------------------------------------
// wishbone_slave_mem
// Wishbone B4 slave backed by a 2**MEM_AW word RAM. Supports classic cycles
// with WAIT_CYCLES wait states and incrementing bursts (linear, wrap-4/8/16)
// with zero-wait registered-feedback beats. Burst beat addresses are
// predicted internally from the previous word index.
//
// Optional feature (macro WB_SLAVE_ADDR_ERR_EN): beats outside the memory
// (ADR_I bits above MEM_AW+1 set, or a linear burst running past the top)
// end with ERR_O, no write and zero read data. Without the macro ERR_O is
// tied low and addresses alias modulo 2**MEM_AW.
//
// Ports:
//   CLK_I     clock
//   RST_I     synchronous active-high reset
//   CYC_I     bus cycle valid
//   STB_I     strobe
//   WE_I      write enable (1 = write)
//   ADR_I     byte address, word index ADR_I[MEM_AW+1:2]
//   DAT_I     write data
//   SEL_I     byte lane enables
//   CTI_I     cycle type identifier
//   BTE_I     burst type extension
//   DAT_O     read data, zero outside ACK cycles
//   ACK_O     normal termination
//   ERR_O     error termination
//   RTY_O     retry, tied low
//   beat_cnt  count of terminated beats (ACK or ERR), wraps at 16 bits
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no cycle in progress, waiting for CYC_I & STB_I
// WAIT  | counting wait states before the first beat
// XFER  | first beat of a cycle, terminates at the next qualifying edge
// BURST | incrementing burst, one beat per edge with CYC_I & STB_I high
// -----------------------------------------------------------------------------
module wishbone_slave_mem
    import wishbone_pkg::*;
#(
    parameter int WB_ADDR_W   = 32,
    parameter int WB_DATA_W   = 32,
    parameter int MEM_AW      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   CYC_I,
    input  logic                   STB_I,
    input  logic                   WE_I,
    input  logic [WB_ADDR_W-1:0]   ADR_I,
    input  logic [WB_DATA_W-1:0]   DAT_I,
    input  logic [WB_DATA_W/8-1:0] SEL_I,
    input  logic [2:0]             CTI_I,
    input  logic [1:0]             BTE_I,
    output logic [WB_DATA_W-1:0]   DAT_O,
    output logic                   ACK_O,
    output logic                   ERR_O,
    output logic                   RTY_O,
    output logic [15:0]            beat_cnt
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    wb_state_e            state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [MEM_AW-1:0]    idx_q, idx_d;

    logic                 ack_q, ack_d;
    logic [15:0]          beat_cnt_q;

    logic [MEM_AW-1:0]    adr_idx;
    logic [MEM_AW-1:0]    cur_idx;
    logic [MEM_AW:0]      lin_sum;
    logic [MEM_AW-1:0]    wmask;
    logic [MEM_AW-1:0]    nxt_idx;
    logic [WB_ADDR_W-MEM_AW-3:0] adr_hi;

    logic                 term;
    logic                 addr_err;
    logic                 ram_we;
    logic                 ram_rd;

    assign adr_idx = ADR_I[MEM_AW+1:2];
    assign adr_hi  = ADR_I[WB_ADDR_W-1:MEM_AW+2];

    // First beat addresses from the bus; later burst beats use the prediction.
    assign cur_idx = (state_q == ST_BURST) ? idx_q : adr_idx;

    assign lin_sum = {1'b0, cur_idx} + (MEM_AW+1)'(1);
    assign wmask   = MEM_AW'(wrap_mask(BTE_I));
    assign nxt_idx = (BTE_I == BTE_LINEAR)
                   ? lin_sum[MEM_AW-1:0]
                   : (cur_idx & ~wmask) | (lin_sum[MEM_AW-1:0] & wmask);

`ifdef WB_SLAVE_ADDR_ERR_EN
    logic ovf_q, ovf_d;
    logic err_q, err_d;
    logic unused_bits;

    // ovf_q marks that the predicted index has run off the top of memory.
    assign addr_err    = (|adr_hi) | ((state_q == ST_BURST) & ovf_q);
    assign unused_bits = ^ADR_I[1:0];
`else
    logic unused_bits;

    assign addr_err    = 1'b0;
    assign unused_bits = ^{ADR_I[1:0], adr_hi, lin_sum[MEM_AW]};
`endif

    // State register
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
`ifdef WB_SLAVE_ADDR_ERR_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
`ifdef WB_SLAVE_ADDR_ERR_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
`ifdef WB_SLAVE_ADDR_ERR_EN
        ovf_d   = ovf_q;
`endif
        if (!CYC_I) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (STB_I) begin
                        if (WAIT_CYCLES > 0) begin
                            state_d = ST_WAIT;
                            wcnt_d  = WAIT_LOAD;
                        end else begin
                            state_d = ST_XFER;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == '0) begin
                        state_d = ST_XFER;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
                ST_XFER: begin
                    if (term) begin
                        if (!addr_err && CTI_I == CTI_INCR) begin
                            state_d = ST_BURST;
                            idx_d   = nxt_idx;
`ifdef WB_SLAVE_ADDR_ERR_EN
                            ovf_d   = (BTE_I == BTE_LINEAR) & lin_sum[MEM_AW];
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_BURST: begin
                    // STB_I low is a master wait: state and prediction hold.
                    if (term) begin
                        idx_d = nxt_idx;
`ifdef WB_SLAVE_ADDR_ERR_EN
                        ovf_d = (BTE_I == BTE_LINEAR) & lin_sum[MEM_AW];
`endif
                        if (addr_err || CTI_I != CTI_INCR) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: a beat terminates on every qualifying edge in XFER/BURST.
    always_comb begin
        term   = !RST_I && CYC_I && STB_I &&
                 (state_q == ST_XFER || state_q == ST_BURST);
        ack_d  = term && !addr_err;
        ram_we = ack_d && WE_I;
        ram_rd = ack_d;
`ifdef WB_SLAVE_ADDR_ERR_EN
        err_d  = term && addr_err;
`endif
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ack_q      <= 1'b0;
            beat_cnt_q <= '0;
`ifdef WB_SLAVE_ADDR_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            ack_q      <= ack_d;
            beat_cnt_q <= beat_cnt_q + {15'd0, term};
`ifdef WB_SLAVE_ADDR_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    wishbone_slave_ram #(
        .AW (MEM_AW),
        .DW (WB_DATA_W)
    ) u_ram (
        .clk_i   (CLK_I),
        .rst_i   (RST_I),
        .addr_i  (cur_idx),
        .we_i    (ram_we),
        .be_i    (SEL_I),
        .wdata_i (DAT_I),
        .rd_en_i (ram_rd),
        .rdata_o (DAT_O)
    );

    assign ACK_O    = ack_q;
    assign RTY_O    = 1'b0;
    assign beat_cnt = beat_cnt_q;
`ifdef WB_SLAVE_ADDR_ERR_EN
    assign ERR_O    = err_q;
`else
    assign ERR_O    = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_wishbone_slave_mem
// Directed bench for wishbone_slave_mem with WAIT_CYCLES=2, MEM_AW=10.
// The address-error case follows WB_SLAVE_ADDR_ERR_EN when defined.
// -----------------------------------------------------------------------------
module tb_wishbone_slave_mem;

    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_r;
    logic        ack, err, rty;
    logic [15:0] beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bdat [4];
    logic [31:0] brd  [4];

    always #5 clk = ~clk;

    wishbone_slave_mem #(
        .WB_ADDR_W   (32),
        .WB_DATA_W   (32),
        .MEM_AW      (10),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .CYC_I    (cyc),
        .STB_I    (stb),
        .WE_I     (we),
        .ADR_I    (adr),
        .DAT_I    (dat_w),
        .SEL_I    (sel),
        .CTI_I    (cti),
        .BTE_I    (bte),
        .DAT_O    (dat_r),
        .ACK_O    (ack),
        .ERR_O    (err),
        .RTY_O    (rty),
        .beat_cnt (beat_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Single classic cycle. lat = clock edges after the sampling edge until
    // the termination is visible.
    task automatic wb_classic(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] rd,
                              output int lat, output logic got_err);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = d; sel = s;
        cti = 3'b000; bte = 2'b00;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!(ack || err) && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check_val("classic_term", 32'(ack | err), 32'd1);
        rd      = dat_r;
        got_err = err;
        check_val("ack_err_excl", 32'(ack & err), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check_val("term_1cyc", 32'(ack | err), 32'd0);
    endtask

    // Incrementing burst. The master presents the next beat as soon as it
    // sees the previous ACK; ADR stays at the start address so the slave
    // must predict. Optional STB drop of stall_len cycles before beat stall_at.
    task automatic wb_burst(input logic wr, input logic [31:0] a, input logic [1:0] bt,
                            input int nb, input int stall_at, input int stall_len,
                            output int gaps, output int extra);
        int k     = 0;
        int guard = 0;
        gaps  = 0;
        extra = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = bdat[0]; sel = 4'hF;
        bte = bt; cti = (nb == 1) ? 3'b111 : 3'b010;
        while (k < nb && guard < 40) begin
            @(negedge clk);
            guard++;
            if (ack) begin
                brd[k] = dat_r;
                k++;
                if (k < nb) begin
                    if (k == stall_at) begin
                        stb = 1'b0;
                        for (int s = 0; s < stall_len; s++) begin
                            @(negedge clk);
                            if (ack || err) gaps++;
                        end
                        stb = 1'b1;
                    end
                    dat_w = bdat[k];
                    cti   = (k == nb - 1) ? 3'b111 : 3'b010;
                end
            end else if (k > 0) begin
                gaps++;
            end
        end
        check_val("burst_beats", k, nb);
        // Hold the bus one more cycle: a finished burst must not ack again.
        @(negedge clk);
        if (ack || err) extra++;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat, gaps, extra, hits, guard;
        logic        e;
        int          wrap_exp [4] = '{3, 0, 1, 2};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        sel = '0; cti = '0; bte = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ack",  32'(ack), 32'd0);
        check_val("rst_err",  32'(err), 32'd0);
        check_val("rst_rty",  32'(rty), 32'd0);
        check_val("rst_dat",  dat_r, 32'd0);
        check_val("rst_cnt",  32'(beat_cnt), 32'd0);
        rst = 1'b0;

        // Classic write/read with two wait states
        wb_classic(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, lat, e);
        check_val("s1_wr_lat", lat, WAIT_CYCLES + 1);
        check_val("s1_wr_err", 32'(e), 32'd0);
        wb_classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, e);
        check_val("s1_rd_lat", lat, WAIT_CYCLES + 1);
        check_val("s1_rd_dat", rd, 32'hDEAD_BEEF);
        check_val("s1_cnt", 32'(beat_cnt), 32'd2);

        // Byte-lane write
        wb_classic(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, rd, lat, e);
        wb_classic(1'b1, 32'h20, 32'h1122_3344, 4'b0101, rd, lat, e);
        wb_classic(1'b0, 32'h20, 32'h0, 4'hF, rd, lat, e);
        check_val("s2_sel_dat", rd, 32'hFF22_FF44);
        check_val("s2_cnt", 32'(beat_cnt), 32'd5);

        // Wrap-4 read burst from 0x0C; word 4 still holds DEADBEEF
        for (int i = 0; i < 4; i++) begin
            wb_classic(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, rd, lat, e);
        end
        wb_burst(1'b0, 32'h0C, 2'b01, 4, -1, 0, gaps, extra);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("s3_wrap_rd%0d", k), brd[k], 32'hA000_0000 + 32'(wrap_exp[k]));
        end
        check_val("s3_ack_consec", gaps, 0);
        check_val("s3_eob_stop", extra, 0);
        check_val("s3_cnt", 32'(beat_cnt), 32'd13);
        wb_classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, e);
        check_val("s3_idle_lat", lat, WAIT_CYCLES + 1);
        check_val("s3_word4", rd, 32'hDEAD_BEEF);

        // Linear write burst at 0x100 with a 2-cycle STB drop before beat 2
        for (int k = 0; k < 4; k++) bdat[k] = 32'hB000_0000 + 32'(k);
        wb_burst(1'b1, 32'h100, 2'b00, 4, 2, 2, gaps, extra);
        check_val("s4_no_stall_ack", gaps, 0);
        check_val("s4_eob_stop", extra, 0);
        check_val("s4_cnt", 32'(beat_cnt), 32'd18);
        for (int k = 0; k < 4; k++) begin
            wb_classic(1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'hF, rd, lat, e);
            check_val($sformatf("s4_lin_rd%0d", k), rd, 32'hB000_0000 + 32'(k));
        end

        // CYC dropped while in WAIT
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_w = 32'h1234_5678;
        sel = 4'hF; cti = 3'b000; bte = 2'b00;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack || err) hits++;
        end
        check_val("s5_no_ack", hits, 0);
        check_val("s5_cnt", 32'(beat_cnt), 32'd22);
        wb_classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, e);
        check_val("s5_idle_lat", lat, WAIT_CYCLES + 1);
        check_val("s5_mem_kept", rd, 32'hDEAD_BEEF);

        // Out-of-range address 0x1000
        wb_classic(1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, rd, lat, e);
        check_val("s6_lat", lat, WAIT_CYCLES + 1);
        check_val("s6_cnt", 32'(beat_cnt), 32'd24);
`ifdef WB_SLAVE_ADDR_ERR_EN
        check_val("s6_err", 32'(e), 32'd1);
        check_val("s6_err_dat", rd, 32'd0);
        wb_classic(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, e);
        check_val("s6_no_write", rd, 32'hA000_0000);
`else
        check_val("s6_err", 32'(e), 32'd0);
        wb_classic(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, e);
        check_val("s6_alias", rd, 32'hCAFE_F00D);
`endif

        // Reset in the middle of a burst
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0C; sel = 4'hF;
        cti = 3'b010; bte = 2'b01;
        guard = 0;
        while (!ack && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("s7_burst_started", 32'(ack), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("s7_rst_ack", 32'(ack), 32'd0);
        check_val("s7_rst_dat", dat_r, 32'd0);
        check_val("s7_rst_cnt", 32'(beat_cnt), 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack || err) hits++;
        end
        check_val("s7_no_ack", hits, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_slave_mem.md
WISHBONE_SLAVE_MEM -- requirements
Module: wishbone_slave_mem

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, named as below.
REQ-002 The block SHALL have these parameters:
- WB_ADDR_W, default 32, byte address width.
- WB_DATA_W, default 32, data width, a multiple of 8.
- MEM_AW, default 10, log2 of the memory depth in words.
- WAIT_CYCLES, default 0, range 0..15, wait states before the first ACK of each cycle.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CLK_I, in, 1, clock.
- RST_I, in, 1, synchronous active-high reset.
- CYC_I, in, 1, bus cycle valid.
- STB_I, in, 1, strobe.
- WE_I, in, 1, write enable (1 = write).
- ADR_I, in, WB_ADDR_W, byte address; word index is ADR_I[MEM_AW+1:2].
- DAT_I, in, WB_DATA_W, write data.
- SEL_I, in, WB_DATA_W/8, byte lane enables.
- CTI_I, in, 3, cycle type: 000 classic, 001 constant address, 010 incrementing, 111 end of burst.
- BTE_I, in, 2, burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- DAT_O, out, WB_DATA_W, read data.
- ACK_O, out, 1, normal termination.
- ERR_O, out, 1, error termination.
- RTY_O, out, 1, retry; constant 0.
- beat_cnt, out, 16, count of terminated beats (ACK or ERR).

Function
REQ-004 The state machine SHALL have four states: IDLE, WAIT, XFER, BURST.
REQ-005 IDLE SHALL be left only when CYC_I&STB_I is sampled high.
- WAIT_CYCLES>0: go to WAIT and load wcnt=WAIT_CYCLES-1.
- WAIT_CYCLES=0: go to XFER.
REQ-006 WAIT SHALL decrement wcnt each cycle and go to XFER when wcnt==0.
REQ-007 In XFER, ACK_O (or ERR_O) SHALL be high for exactly one cycle. A request first sampled at edge N terminates in the cycle after edge N+1+WAIT_CYCLES.
REQ-008 On leaving XFER, the next state SHALL be:
- BURST, if CTI_I==010 and CTI_I!=111 at the termination edge;
- IDLE, otherwise (classic, constant-address, or 111).
REQ-009 In BURST, ACK_O SHALL be asserted in every cycle where CYC_I&STB_I is high, giving back-to-back zero-wait beats via registered feedback.
REQ-010 The BURST beat address SHALL be predicted internally from the previous word index, not taken from ADR_I:
- linear: +1;
- wrap-4/8/16: low 2/3/4 bits increment modulo 4/8/16, upper bits held.
REQ-011 A BURST beat with CTI_I==111 SHALL be the last; the next state is IDLE.
REQ-012 In BURST, STB_I low with CYC_I high SHALL insert a master wait: no ACK, state held, predicted address held.
REQ-013 CYC_I low in any state SHALL force IDLE at the next edge, with ACK_O/ERR_O low in that cycle; no write occurs.
REQ-014 A write SHALL occur only in a terminating ACK cycle with WE_I=1, updating only the byte lanes whose SEL_I bit is set.
REQ-015 Read DAT_O SHALL be valid in every ACK cycle. When not acking, DAT_O SHALL be 0.
REQ-016 beat_cnt SHALL increment by 1 per ACK or ERR cycle and wrap from 0xFFFF to 0.
REQ-017 ACK_O and ERR_O SHALL never be high together.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 When RST_I=1 at an edge, the block SHALL go to IDLE with wcnt=0, ACK_O=0, ERR_O=0, DAT_O=0, and beat_cnt=0.
REQ-020 Reset mid-burst SHALL abort with no further ACK.
REQ-021 Memory contents SHALL NOT be reset.

Configuration
REQ-022 With macro WB_SLAVE_ADDR_ERR_EN defined, a beat whose ADR_I bits above MEM_AW+1 are nonzero, or whose predicted burst address overflows 2^MEM_AW, SHALL terminate with ERR_O instead of ACK_O, perform no write, return DAT_O=0, and send the state machine to IDLE.
REQ-023 Without WB_SLAVE_ADDR_ERR_EN, ERR_O SHALL be constant 0 and out-of-range addresses SHALL alias modulo 2^MEM_AW.

Structure
REQ-024 The CTI and BTE encodings and the state enum SHALL live in the shared package wishbone_pkg, reused by the master and the UVC.
REQ-025 Storage SHALL be a sub-module wishbone_slave_ram: single-port, synchronous read, per-byte write enable, depth 2^MEM_AW.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Classic write 0xDEADBEEF to 0x10 with SEL=1111, then read 0x10, WAIT_CYCLES=2 -> each ACK arrives 3 cycles after STB; read returns 0xDEADBEEF.
- SEL=0101 write 0x11223344 over 0xFFFFFFFF at 0x20 -> read returns 0xFF22FF44.
- Incrementing wrap-4 read starting at 0x0C, 4 beats with the last CTI=111 -> word indices 3,0,1,2; ACK high 4 consecutive cycles after the first; then IDLE.
- Linear burst with STB dropped for 2 cycles mid-burst -> no ACK in those cycles; the address resumes at the next index; beat_cnt advances by the beat count only.
- CYC_I dropped during WAIT -> no ACK; memory unchanged; IDLE next cycle.
- With WB_SLAVE_ADDR_ERR_EN, MEM_AW=10, access to 0x1000 -> ERR_O for one cycle, no write, beat_cnt+1; without the macro -> ACK and alias to word 0.
